fwd_issue: RTL and testbench
============================

# fwd_issue

Parametrised operand forwarding and issue unit sitting between decode (ID) and execute (EX) of the in-order pipeline. Tracks destination registers of in-flight instructions in EX, MEM and WB, selects each operand from the register file or the youngest matching in-flight result, applies the auipc/immediate/jump operand overrides, and registers the final operands into the ID/EX boundary. Detects load-use hazards, stalls ID for one cycle while inserting a bubble, honours branch flush, and counts stall cycles.

## Interface
- XLEN, 32: datapath width.
- NREG, 32: register count; RA_W = $clog2(NREG). Register 0 is hard-wired zero.
- CNT_W, 32: stall counter width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_id_valid  in  1  ID holds an instruction.
- o_id_ready  out  1  ID instruction consumed this cycle (issued or flushed).
- i_rs1, i_rs2  in  RA_W  source register addresses.
- i_rs1_used, i_rs2_used  in  1  source actually read.
- i_rd  in  RA_W  destination register; i_rd_we  in  1  writes rd; i_is_load  in  1  load.
- i_auipc, i_imm, i_jal, i_jalr  in  1  operand overrides.
- i_pc, i_imm_val  in  XLEN  PC and immediate of ID instruction.
- i_rs1_rdata, i_rs2_rdata  in  XLEN  register file read data.
- i_ex_res  in  XLEN  ALU result of instruction currently in EX.
- i_mem_res  in  XLEN  ALU result held in MEM; i_mem_ldata  in  XLEN  load data in MEM.
- i_wb_data  in  XLEN  write-back data in WB.
- i_flush  in  1  discard ID instruction.
- o_ex_valid  out  1  registered: EX holds a real instruction.
- o_op1, o_op2  out  XLEN  registered ALU operands.
- o_store_data  out  XLEN  registered forwarded rs2 value.
- o_stall_cnt  out  CNT_W  saturating load-use stall cycle count.

## Operation
- Internal slots EX, MEM, WB, each {valid, rd, we, load}. Every cycle EX->MEM->WB->discard unconditionally; EX refilled from ID on issue, else with a bubble (valid=0).
- Slot "matches" rsN when valid & we & rd != 0 & rd == rsN & rsN_used.
- Forwarded rsN priority: EX match -> i_ex_res; else MEM match -> (MEM.load ? i_mem_ldata : i_mem_res); else WB match -> i_wb_data; else i_rsN_rdata. rsN == 0 always yields 0.
- Load-use hazard: EX match on rs1 or rs2 with EX.load = 1. Then stall = i_id_valid & hazard & !i_flush.
- o_id_ready = i_id_valid & !stall. Issue = o_id_ready & !i_flush.
- Operand rules (on issued values): op1 = i_auipc ? i_pc : fwd_rs1; op2 = i_imm ? i_imm_val : (i_jal | i_jalr) ? 4 : fwd_rs2; store_data = fwd_rs2.
- On issue: register op1/op2/store_data, o_ex_valid = 1, EX slot <= {1, i_rd, i_rd_we, i_is_load}. Otherwise o_ex_valid = 0, EX slot invalid, op registers hold previous values.
- Flush overrides stall: flushed instruction is consumed (ready = 1), never enters EX; stall counter does not increment.
- Stall counter: +1 each stall cycle, saturates at 2^CNT_W - 1.

## Timing
- Reset (async assert, sync release): all slots invalid, o_ex_valid = 0, o_op1 = o_op2 = o_store_data = 0, o_stall_cnt = 0; o_id_ready combinational (1 if i_id_valid and no hazard).
- Issue at cycle t: operands visible t+1 (EX), slot in MEM t+2, WB t+3, gone t+4. RF read in same cycle as WB write returns stale data; WB forward covers it.
- Load-use: exactly one stall cycle; next cycle load is in MEM and forwards i_mem_ldata.
- o_id_ready and forwarding selects are combinational from current slots and ID inputs; no combinational path from i_ex_res etc. to o_id_ready.
- Reset mid-stall: slots cleared, stall released on first cycle after deassertion.

## Test plan
- add x5 then add x6,x5,x1 back-to-back, i_ex_res = 0x11 -> o_op1 = 0x11 next cycle, no stall.
- lw x7 then add x8,x7,x7 -> one cycle o_id_ready = 0, o_ex_valid = 0, counter 1; next cycle i_mem_ldata = 0xCAFE -> o_op1 = o_op2 = 0xCAFE.
- Writer of x0 followed by reader of x0, i_ex_res = 0xFFFF -> o_op1 = 0.
- x9 written 3 instructions earlier, i_wb_data = 0x55, i_rs1_rdata = 0x99 -> o_op1 = 0x55; x9 also matching in MEM (0x66) -> 0x66 wins.
- Load-use stall with i_flush = 1 -> o_id_ready = 1, o_ex_valid = 0 next cycle, counter unchanged; jal with i_pc = 0x100 -> op1 = 0x100, op2 = 4.
- CNT_W = 4, 20 load-use stalls -> o_stall_cnt = 15; assert i_rst_n = 0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/fwd_issue.sv
// ID->EX operand forwarding/issue: operands registered one cycle after issue.
// Load-use hazard holds ID one cycle (o_id_ready low) and inserts a bubble; flush always consumes.
module fwd_issue #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  output logic             o_id_ready,
  input  logic [RA_W-1:0]  i_rs1,
  input  logic [RA_W-1:0]  i_rs2,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic [RA_W-1:0]  i_rd,
  input  logic             i_rd_we,
  input  logic             i_is_load,
  input  logic             i_auipc,
  input  logic             i_imm,
  input  logic             i_jal,
  input  logic             i_jalr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm_val,
  input  logic [XLEN-1:0]  i_rs1_rdata,
  input  logic [XLEN-1:0]  i_rs2_rdata,
  input  logic [XLEN-1:0]  i_ex_res,
  input  logic [XLEN-1:0]  i_mem_res,
  input  logic [XLEN-1:0]  i_mem_ldata,
  input  logic [XLEN-1:0]  i_wb_data,
  input  logic             i_flush,
  output logic             o_ex_valid,
  output logic [XLEN-1:0]  o_op1,
  output logic [XLEN-1:0]  o_op2,
  output logic [XLEN-1:0]  o_store_data,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            load;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot;

  function automatic logic slot_hit(input slot_t s, input logic [RA_W-1:0] rs, input logic used);
    return s.valid && s.we && (s.rd != '0) && (s.rd == rs) && used;
  endfunction

  // Youngest in-flight producer wins; x0 reads as zero even when the RF returns garbage.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] rs, input logic used, input logic [XLEN-1:0] rdata,
    input slot_t ex_s, input slot_t mem_s, input slot_t wb_s,
    input logic [XLEN-1:0] ex_res, input logic [XLEN-1:0] mem_res,
    input logic [XLEN-1:0] mem_ldata, input logic [XLEN-1:0] wb_data);
    if (rs == '0)                      return '0;
    if (slot_hit(ex_s, rs, used))      return ex_res;
    if (slot_hit(mem_s, rs, used))     return mem_s.load ? mem_ldata : mem_res;
    if (slot_hit(wb_s, rs, used))      return wb_data;
    return rdata;
  endfunction

  logic            hazard, stall, issue;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op1_nxt, op2_nxt;

  always_comb begin
    hazard  = ex_slot.load && (slot_hit(ex_slot, i_rs1, i_rs1_used) ||
                               slot_hit(ex_slot, i_rs2, i_rs2_used));
    stall   = i_id_valid && hazard && !i_flush;
    o_id_ready = i_id_valid && !stall;
    issue   = o_id_ready && !i_flush;
    fwd_rs1 = fwd_sel(i_rs1, i_rs1_used, i_rs1_rdata, ex_slot, mem_slot, wb_slot,
                      i_ex_res, i_mem_res, i_mem_ldata, i_wb_data);
    fwd_rs2 = fwd_sel(i_rs2, i_rs2_used, i_rs2_rdata, ex_slot, mem_slot, wb_slot,
                      i_ex_res, i_mem_res, i_mem_ldata, i_wb_data);
    op1_nxt = i_auipc ? i_pc : fwd_rs1;
    if (i_imm)                op2_nxt = i_imm_val;
    else if (i_jal || i_jalr) op2_nxt = XLEN'(4);
    else                      op2_nxt = fwd_rs2;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_slot      <= '0;
      mem_slot     <= '0;
      wb_slot      <= '0;
      o_ex_valid   <= 1'b0;
      o_op1        <= '0;
      o_op2        <= '0;
      o_store_data <= '0;
      o_stall_cnt  <= '0;
    end else begin
      mem_slot   <= ex_slot;
      wb_slot    <= mem_slot;
      o_ex_valid <= issue;
      if (issue) begin
        ex_slot      <= '{valid: 1'b1, rd: i_rd, we: i_rd_we, load: i_is_load};
        o_op1        <= op1_nxt;
        o_op2        <= op2_nxt;
        o_store_data <= fwd_rs2;
      end else begin
        ex_slot <= '0;
      end
      if (stall && (o_stall_cnt != {CNT_W{1'b1}}))
        o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_issue.sv
// Randomized and directed bench for fwd_issue against an issue-history reference model.
module tb_fwd_issue;
  localparam int XLEN = 32, NREG = 32, CNT_W = 4, RA_W = 5;
  localparam int CNT_MAX = 15;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst_n, i_id_valid, o_id_ready;
  logic [RA_W-1:0] i_rs1, i_rs2, i_rd;
  logic i_rs1_used, i_rs2_used, i_rd_we, i_is_load;
  logic i_auipc, i_imm, i_jal, i_jalr, i_flush;
  logic [XLEN-1:0] i_pc, i_imm_val, i_rs1_rdata, i_rs2_rdata;
  logic [XLEN-1:0] i_ex_res, i_mem_res, i_mem_ldata, i_wb_data;
  logic o_ex_valid;
  logic [XLEN-1:0] o_op1, o_op2, o_store_data;
  logic [CNT_W-1:0] o_stall_cnt;

  fwd_issue #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd(i_rd), .i_rd_we(i_rd_we), .i_is_load(i_is_load),
    .i_auipc(i_auipc), .i_imm(i_imm), .i_jal(i_jal), .i_jalr(i_jalr),
    .i_pc(i_pc), .i_imm_val(i_imm_val), .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
    .i_ex_res(i_ex_res), .i_mem_res(i_mem_res), .i_mem_ldata(i_mem_ldata), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_ex_valid(o_ex_valid), .o_op1(o_op1), .o_op2(o_op2),
    .o_store_data(o_store_data), .o_stall_cnt(o_stall_cnt)
  );

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: list of issued instructions tagged with their issue cycle.
  // An instruction issued k cycles ago (k = 1,2,3) produces the EX, MEM, WB result respectively.
  typedef struct {
    int              cyc;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            load;
  } rec_t;

  rec_t iss[$];
  int cyc = 0;
  logic            m_vld;
  logic [XLEN-1:0] m_op1, m_op2, m_sd;
  int              m_cnt;

  function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] rs, input logic used,
                                               input logic [XLEN-1:0] rdata);
    if (rs == 0) return '0;
    if (used)
      for (int age = 1; age <= 3; age++)
        foreach (iss[i])
          if ((cyc - iss[i].cyc) == age && iss[i].we && iss[i].rd == rs)
            return (age == 1) ? i_ex_res : (age == 2) ? (iss[i].load ? i_mem_ldata : i_mem_res) : i_wb_data;
    return rdata;
  endfunction

  function automatic logic ref_hazard();
    foreach (iss[i])
      if ((cyc - iss[i].cyc) == 1 && iss[i].load && iss[i].we && iss[i].rd != 0 &&
          ((i_rs1_used && iss[i].rd == i_rs1) || (i_rs2_used && iss[i].rd == i_rs2)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    iss.delete();
    m_vld = 0; m_op1 = '0; m_op2 = '0; m_sd = '0; m_cnt = 0;
  endtask

  task automatic set_idle();
    i_id_valid = 0; i_rs1 = 0; i_rs2 = 0; i_rs1_used = 0; i_rs2_used = 0;
    i_rd = 0; i_rd_we = 0; i_is_load = 0; i_auipc = 0; i_imm = 0; i_jal = 0; i_jalr = 0;
    i_flush = 0; i_pc = '0; i_imm_val = '0; i_rs1_rdata = '0; i_rs2_rdata = '0;
    i_ex_res = '0; i_mem_res = '0; i_mem_ldata = '0; i_wb_data = '0;
  endtask

  task automatic set_instr(input int rd, input bit we, input bit load,
                           input int rs1, input bit u1, input int rs2, input bit u2);
    set_idle();
    i_id_valid = 1; i_rd = RA_W'(rd); i_rd_we = we; i_is_load = load;
    i_rs1 = RA_W'(rs1); i_rs1_used = u1; i_rs2 = RA_W'(rs2); i_rs2_used = u2;
  endtask

  // One clock: check combinational ready mid-cycle, then registered outputs after the edge.
  task automatic step(input string tag);
    logic stall, rdy, issue;
    logic [XLEN-1:0] f1, f2;
    @(negedge i_clk);
    stall = i_id_valid && ref_hazard() && !i_flush;
    rdy   = i_id_valid && !stall;
    check_eq({tag, ".rdy"}, XLEN'(o_id_ready), XLEN'(rdy));
    issue = rdy && !i_flush;
    f1 = ref_fwd(i_rs1, i_rs1_used, i_rs1_rdata);
    f2 = ref_fwd(i_rs2, i_rs2_used, i_rs2_rdata);
    @(posedge i_clk);
    if (issue) begin
      m_op1 = i_auipc ? i_pc : f1;
      m_op2 = i_imm ? i_imm_val : (i_jal || i_jalr) ? 32'd4 : f2;
      m_sd  = f2;
      iss.push_back('{cyc: cyc, rd: i_rd, we: i_rd_we, load: i_is_load});
    end
    m_vld = issue;
    if (stall && m_cnt < CNT_MAX) m_cnt++;
    cyc++;
    while (iss.size() > 0 && (cyc - iss[0].cyc) > 3) void'(iss.pop_front());
    #1;
    check_eq({tag, ".vld"}, XLEN'(o_ex_valid), XLEN'(m_vld));
    check_eq({tag, ".op1"}, o_op1, m_op1);
    check_eq({tag, ".op2"}, o_op2, m_op2);
    check_eq({tag, ".sd"}, o_store_data, m_sd);
    check_eq({tag, ".cnt"}, XLEN'(o_stall_cnt), XLEN'(m_cnt));
  endtask

  task automatic apply_reset();
    i_rst_n = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
  endtask

  initial begin
    set_idle();
    model_reset();
    apply_reset();
    check_eq("rst.vld", XLEN'(o_ex_valid), '0);
    check_eq("rst.op1", o_op1, '0);
    check_eq("rst.cnt", XLEN'(o_stall_cnt), '0);

    // EX forwarding back-to-back
    set_instr(5, 1, 0, 1, 1, 2, 1); step("ex1");
    set_instr(6, 1, 0, 5, 1, 1, 1); i_ex_res = 32'h11; i_rs1_rdata = 32'h77; step("ex2");
    check_eq("ex_fwd.op1", o_op1, 32'h11);

    // Load-use: one stall, then load data from MEM
    set_instr(7, 1, 1, 0, 0, 0, 0); step("lu1");
    set_instr(8, 1, 0, 7, 1, 7, 1); step("lu2");
    check_eq("lu.vld", XLEN'(o_ex_valid), '0);
    check_eq("lu.cnt", XLEN'(o_stall_cnt), 32'd1);
    i_mem_ldata = 32'hCAFE; i_mem_res = 32'h1234; step("lu3");
    check_eq("lu.op1", o_op1, 32'hCAFE);
    check_eq("lu.op2", o_op2, 32'hCAFE);

    // x0 never forwards
    set_instr(0, 1, 0, 1, 1, 2, 1); step("x0a");
    set_instr(3, 1, 0, 0, 1, 0, 1); i_ex_res = 32'hFFFF; i_rs1_rdata = 32'h1; step("x0b");
    check_eq("x0.op1", o_op1, '0);

    // WB forward, then MEM beats WB
    set_instr(9, 1, 0, 1, 1, 2, 1); step("wb1");
    set_instr(1, 0, 0, 0, 0, 0, 0); step("wb2");
    set_instr(1, 0, 0, 0, 0, 0, 0); step("wb3");
    set_instr(4, 1, 0, 9, 1, 0, 0); i_wb_data = 32'h55; i_rs1_rdata = 32'h99; step("wb4");
    check_eq("wb.op1", o_op1, 32'h55);
    set_instr(9, 1, 0, 0, 0, 0, 0); step("mw1");
    set_instr(9, 1, 0, 0, 0, 0, 0); step("mw2");
    set_instr(1, 0, 0, 0, 0, 0, 0); step("mw3");
    set_instr(4, 1, 0, 9, 1, 0, 0); i_wb_data = 32'h55; i_mem_res = 32'h66; i_rs1_rdata = 32'h99; step("mw4");
    check_eq("mem_over_wb.op1", o_op1, 32'h66);

    // Flush overrides stall; jal operands
    set_instr(7, 1, 1, 0, 0, 0, 0); step("fl1");
    set_instr(8, 1, 0, 7, 1, 0, 0); i_flush = 1; step("fl2");
    check_eq("flush.vld", XLEN'(o_ex_valid), '0);
    check_eq("flush.cnt", XLEN'(o_stall_cnt), 32'd1);
    set_instr(1, 1, 0, 0, 0, 0, 0); i_auipc = 1; i_jal = 1; i_pc = 32'h100; step("jal");
    check_eq("jal.op1", o_op1, 32'h100);
    check_eq("jal.op2", o_op2, 32'd4);

    // Saturating stall counter
    for (int n = 0; n < 20; n++) begin
      set_instr(7, 1, 1, 0, 0, 0, 0); step("sat_ld");
      set_instr(8, 1, 0, 7, 1, 0, 0); step("sat_st");
      step("sat_go");
    end
    check_eq("sat.cnt", XLEN'(o_stall_cnt), 32'd15);

    // Reset in the middle of a stall
    set_instr(7, 1, 1, 0, 0, 0, 0); step("rm1");
    set_instr(8, 1, 0, 7, 1, 0, 0);
    @(negedge i_clk);
    check_eq("rm.stall_rdy", XLEN'(o_id_ready), '0);
    i_rst_n = 0;
    model_reset();
    #1;
    check_eq("rm.vld", XLEN'(o_ex_valid), '0);
    check_eq("rm.op1", o_op1, '0);
    check_eq("rm.op2", o_op2, '0);
    check_eq("rm.sd", o_store_data, '0);
    check_eq("rm.cnt", XLEN'(o_stall_cnt), '0);
    check_eq("rm.rdy", XLEN'(o_id_ready), 32'd1);
    @(posedge i_clk); #1;
    i_rst_n = 1;
    step("rm2");

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 299) begin
        set_idle();
        apply_reset();
      end
      set_idle();
      i_id_valid  = ($urandom_range(0, 9) < 8);
      i_rs1       = RA_W'($urandom_range(0, 7));
      i_rs2       = RA_W'($urandom_range(0, 7));
      i_rs1_used  = ($urandom_range(0, 9) < 8);
      i_rs2_used  = ($urandom_range(0, 9) < 6);
      i_rd        = RA_W'($urandom_range(0, 7));
      i_rd_we     = ($urandom_range(0, 9) < 8);
      i_is_load   = ($urandom_range(0, 9) < 3);
      i_auipc     = ($urandom_range(0, 9) < 1);
      i_imm       = ($urandom_range(0, 9) < 2);
      i_jal       = ($urandom_range(0, 19) < 1);
      i_jalr      = ($urandom_range(0, 19) < 1);
      i_flush     = ($urandom_range(0, 19) < 1);
      i_pc        = $urandom;
      i_imm_val   = $urandom;
      i_rs1_rdata = $urandom;
      i_rs2_rdata = $urandom;
      i_ex_res    = $urandom;
      i_mem_res   = $urandom;
      i_mem_ldata = $urandom;
      i_wb_data   = $urandom;
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
